// File: rtl/clks_pkg.sv
// Shared clocking types and helpers for clock-enable checkers.
package clks_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } meter_state_t;

  // Window test done in 33 bits so expected+tol cannot wrap; the lower bound clamps at 0.
  function automatic bit in_tolerance(input logic [32:0] period,
                                      input logic [32:0] expected,
                                      input logic [32:0] tol);
    logic [32:0] lo;
    logic [32:0] hi;
    lo = (expected >= tol) ? (expected - tol) : 33'd0;
    hi = expected + tol;
    return (period >= lo) && (period <= hi);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that stops at MAX; clear wins over inc, synchronous active-high reset.
module sat_counter #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] MAX   = '1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] value,
  output logic             saturated
);

  assign saturated = (value == MAX);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      value <= '0;
    end else if (inc && !saturated) begin
      value <= value + 1'b1;
    end
  end

endmodule

// File: rtl/clk_en_period_meter.sv
// Measures clk cycles between clk_en_in pulses, publishes them on valid/ready and tracks lock.
// Optional min/max statistics are enabled by defining CLK_EN_METER_STATS_EN.
module clk_en_period_meter
  import clks_pkg::*;
#(
  parameter int EXPECTED_PERIOD = 256,
  parameter int TOLERANCE       = 0,
  parameter int LOCK_COUNT      = 4,
  parameter int CNT_WIDTH       = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clk_en_in,
  output logic [CNT_WIDTH-1:0] period,
  output logic                 period_valid,
  input  logic                 period_ready,
  output logic                 period_err,
  output logic                 locked,
  output logic                 overflow,
  output logic                 dropped,
  output meter_state_t         state
`ifdef CLK_EN_METER_STATS_EN
  ,
  input  logic                 stats_clear,
  output logic [CNT_WIDTH-1:0] period_min,
  output logic [CNT_WIDTH-1:0] period_max
`endif
);

  localparam int SW = $clog2(LOCK_COUNT + 1);

  logic [CNT_WIDTH-1:0] cnt;
  logic                 cnt_sat;
  logic [CNT_WIDTH-1:0] cap;
  logic                 cap_bad;
  logic                 capture;
  logic [SW-1:0]        streak;
  logic                 streak_sat;

  assign capture = (state == MEASURE) && clk_en_in;
  assign cap     = cnt_sat ? cnt : cnt + 1'b1;
  // An all-ones capture means the true period is unknown, so it never counts as in-spec.
  assign cap_bad = (cap == '1) ||
                   !in_tolerance(33'(cap), 33'(EXPECTED_PERIOD), 33'(TOLERANCE));

  sat_counter #(.WIDTH(CNT_WIDTH)) u_cnt (
    .clk       (clk),
    .reset     (reset),
    .clear     (clk_en_in),
    .inc       ((state == MEASURE) && !clk_en_in),
    .value     (cnt),
    .saturated (cnt_sat)
  );

  sat_counter #(.WIDTH(SW), .MAX(SW'(LOCK_COUNT))) u_streak (
    .clk       (clk),
    .reset     (reset),
    .clear     (capture && cap_bad),
    .inc       (capture && !cap_bad),
    .value     (streak),
    .saturated (streak_sat)
  );

  assign locked = streak_sat;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      period       <= '0;
      period_valid <= 1'b0;
      period_err   <= 1'b0;
      overflow     <= 1'b0;
      dropped      <= 1'b0;
    end else begin
      period_err <= 1'b0;
      case (state)
        IDLE:    if (clk_en_in) state <= MEASURE;
        MEASURE: if (cnt_sat) overflow <= 1'b1;
        default: state <= IDLE;
      endcase
      if (capture) begin
        period       <= cap;
        period_valid <= 1'b1;
        period_err   <= cap_bad;
        // Overwriting an unaccepted value loses it; a same-cycle accept does not.
        if (period_valid && !period_ready) dropped <= 1'b1;
      end else if (period_valid && period_ready) begin
        period_valid <= 1'b0;
      end
    end
  end

`ifdef CLK_EN_METER_STATS_EN
  always_ff @(posedge clk) begin
    if (reset || stats_clear) begin
      period_min <= '1;
      period_max <= '0;
    end else if (capture) begin
      if (cap < period_min) period_min <= cap;
      if (cap > period_max) period_max <= cap;
    end
  end
`endif

endmodule

// File: tb/tb_clk_en_period_meter.sv
// Randomized bench: pulse-time model feeds an expected-period queue drained by an output monitor.
module tb_clk_en_period_meter;

  localparam int EXP  = 8;
  localparam int TOL  = 0;
  localparam int LOCK = 4;
  localparam int W    = 4;
  localparam int ALL1 = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         clk_en_in = 1'b0;
  logic [W-1:0] period;
  logic         period_valid;
  logic         period_ready = 1'b0;
  logic         period_err;
  logic         locked;
  logic         overflow;
  logic         dropped;
  clks_pkg::meter_state_t state_dbg;
`ifdef CLK_EN_METER_STATS_EN
  logic         stats_clear = 1'b0;
  logic [W-1:0] period_min;
  logic [W-1:0] period_max;
`endif

  clk_en_period_meter #(
    .EXPECTED_PERIOD (EXP),
    .TOLERANCE       (TOL),
    .LOCK_COUNT      (LOCK),
    .CNT_WIDTH       (W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .clk_en_in    (clk_en_in),
    .period       (period),
    .period_valid (period_valid),
    .period_ready (period_ready),
    .period_err   (period_err),
    .locked       (locked),
    .overflow     (overflow),
    .dropped      (dropped),
    .state        (state_dbg)
`ifdef CLK_EN_METER_STATS_EN
    ,
    .stats_clear  (stats_clear),
    .period_min   (period_min),
    .period_max   (period_max)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    bit valid;
    bit err;
    bit lck;
    bit ovf;
    bit drop;
    int mn;
    int mx;
  } exp_t;

  logic [W-1:0] exp_q[$];
  exp_t cur, nxt;
  int   checks = 0;
  int   failures = 0;
  bit   mon_en = 1'b0;

  // model state
  int cyc = 0;
  bit armed = 0;
  int last = 0;
  int streak = 0;
  bit pend = 0;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic step(input bit rst, input bit pulse, input bit rdy, input bit sclr);
    int  p;
    int  cap;
    bit  captured;
    bit  bad;
    @(posedge clk);
    #1;
    cur = nxt;
    reset        = rst;
    clk_en_in    = pulse;
    period_ready = rdy;
`ifdef CLK_EN_METER_STATS_EN
    stats_clear  = sclr;
`endif
    cyc++;
    captured = 0;
    nxt.err  = 0;
    if (rst) begin
      armed = 0; streak = 0; pend = 0;
      exp_q.delete();
      nxt = '{valid: 0, err: 0, lck: 0, ovf: 0, drop: 0, mn: ALL1, mx: 0};
    end else begin
      if (armed && (cyc - last) >= (1 << W)) nxt.ovf = 1;
      if (pulse) begin
        if (armed) begin
          p   = cyc - last;
          cap = (p > ALL1) ? ALL1 : p;
          bad = (cap == ALL1) || (cap < ((EXP > TOL) ? EXP - TOL : 0)) || (cap > EXP + TOL);
          captured = 1;
        end
        armed = 1;
        last  = cyc;
      end
      if (captured) begin
        if (pend && !rdy) begin
          void'(exp_q.pop_back());
          nxt.drop = 1;
        end
        exp_q.push_back(W'(cap));
        pend    = 1;
        nxt.err = bad;
        streak  = bad ? 0 : ((streak < LOCK) ? streak + 1 : LOCK);
      end else if (pend && rdy) begin
        pend = 0;
      end
      if (sclr) begin
        nxt.mn = ALL1;
        nxt.mx = 0;
      end else if (captured) begin
        if (cap < nxt.mn) nxt.mn = cap;
        if (cap > nxt.mx) nxt.mx = cap;
      end
      nxt.valid = pend;
      nxt.lck   = (streak == LOCK);
    end
    if (sclr && rst) begin
      nxt.mn = ALL1;
      nxt.mx = 0;
    end
  endtask

  function automatic bit rd(input int mode);
    if (mode == 0) return 1'b0;
    if (mode == 1) return 1'b1;
    return ($urandom_range(0, 3) != 0);
  endfunction

  task automatic pulse_gap(input int gap, input int rmode);
    step(0, 1, rd(rmode), 0);
    repeat (gap - 1) step(0, 0, rd(rmode), 0);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      chk("period_valid", period_valid, cur.valid);
      chk("period_err", period_err, cur.err);
      chk("locked", locked, cur.lck);
      chk("overflow", overflow, cur.ovf);
      chk("dropped", dropped, cur.drop);
`ifdef CLK_EN_METER_STATS_EN
      chk("period_min", period_min, cur.mn);
      chk("period_max", period_max, cur.mx);
`endif
      if (period_valid && period_ready && !reset) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL accept_without_expected: got period %0d expected none (t=%0t)", period, $time);
        end else begin
          chk("period", period, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    nxt = '{valid: 0, err: 0, lck: 0, ovf: 0, drop: 0, mn: ALL1, mx: 0};
    repeat (3) step(1, 0, 1, 0);
    mon_en = 1'b1;
    // nominal stream locks on the 4th measurement
    repeat (6) pulse_gap(8, 1);
    // one long gap breaks lock, then relock
    pulse_gap(10, 1);
    repeat (6) pulse_gap(8, 1);
    // ready held low across two captures
    pulse_gap(8, 0);
    pulse_gap(9, 0);
    pulse_gap(3, 0);
    pulse_gap(8, 1);
    // counter saturation
    pulse_gap(40, 1);
    pulse_gap(8, 1);
    // reset in the middle of a measurement
    step(0, 1, 1, 0);
    repeat (3) step(0, 0, 1, 0);
    repeat (2) step(1, 0, 1, 0);
    repeat (3) pulse_gap(8, 1);
    // continuous enable
    repeat (6) pulse_gap(1, 1);
    repeat (3) pulse_gap(8, 1);
    // randomized traffic
    for (int i = 0; i < 300; i++) begin
      int g;
      g = ($urandom_range(0, 9) < 6) ? 8 : $urandom_range(1, 14);
      step(0, 1, rd(2), ($urandom_range(0, 49) == 0));
      repeat (g - 1) step(0, 0, rd(2), 0);
    end
    repeat (4) step(0, 0, 1, 0);
    chk("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
